// File: rtl/alu_pkg.sv
// Shared encodings for the single-issue ALU sequencer: ALU control codes,
// RV32I opcodes and funct7 values, FSM state encoding and operand helpers.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

    function automatic logic [31:0] shamt_ext(input logic [4:0] amt);
        return {27'b0, amt};
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational RV32I integer-ALU decoder: selects operands and ALU control
// for R-type and I-type arithmetic/logic/shift ops, flags anything else.
module alu_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // rd and rs1 fields are consumed by the sequencer, not the decoder
    assign unused_fields = ^instr[19:7];

    always_comb begin
        alu_a    = rs1_data;
        alu_b    = rs2_data;
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     alu_ctrl = ALU_ADD;
                        else if (funct7 == F7_ALT) alu_ctrl = ALU_SUB;
                        else                       illegal  = 1'b1;
                    end
                    3'b111: begin
                        alu_ctrl = ALU_AND;
                        illegal  = (funct7 != F7_BASE);
                    end
                    3'b110: begin
                        alu_ctrl = ALU_OR;
                        illegal  = (funct7 != F7_BASE);
                    end
                    3'b100: begin
                        alu_ctrl = ALU_XOR;
                        illegal  = (funct7 != F7_BASE);
                    end
                    3'b001: begin
                        alu_ctrl = ALU_SLL;
                        alu_b    = shamt_ext(rs2_data[4:0]);
                        illegal  = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        alu_b = shamt_ext(rs2_data[4:0]);
                        if (funct7 == F7_BASE)     alu_ctrl = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_ctrl = ALU_SRA;
                        else                       illegal  = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                alu_b = sext12(instr[31:20]);
                case (funct3)
                    3'b000: alu_ctrl = ALU_ADD;
                    3'b111: alu_ctrl = ALU_AND;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b001: begin
                        alu_ctrl = ALU_SLL;
                        alu_b    = shamt_ext(instr[24:20]);
                        illegal  = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        alu_b = shamt_ext(instr[24:20]);
                        if (funct7 == F7_BASE)     alu_ctrl = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_ctrl = ALU_SRA;
                        else                       illegal  = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single-instruction issue sequencer around an external 32-bit ALU and
// register file: accept, decode, execute, write back, one at a time.
//
// state  | meaning
// IDLE   | ready for a new instruction
// DECODE | read registers, register ALU operands and control
// EXEC   | capture ALU result and destination
// WB     | one-cycle register write (suppressed for x0)
// ERR    | one-cycle illegal pulse, no write
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        illegal,
    output logic        busy
);

    state_e      state;
    logic [31:0] instr_q;
    logic        rd_we_q;
    logic        illegal_q;

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [2:0]  dec_ctrl;
    logic        dec_illegal;

    alu_dec u_dec (
        .instr    (instr_q),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_a    (dec_a),
        .alu_b    (dec_b),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

    assign rs1_addr = instr_q[19:15];
    assign rs2_addr = instr_q[24:20];

    // Strobes are masked by rst so a reset asserted mid-cycle silences them at once
    assign instr_ready = (state == S_IDLE) && !rst;
    assign busy        = (state != S_IDLE) && !rst;
    assign rd_we       = rd_we_q && !rst;
    assign illegal     = illegal_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            instr_q   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= ALU_ADD;
            rd_addr   <= '0;
            rd_wdata  <= '0;
            rd_we_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_we_q   <= 1'b0;
                    illegal_q <= 1'b0;
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        alu_a    <= dec_a;
                        alu_b    <= dec_b;
                        alu_ctrl <= dec_ctrl;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rd_wdata <= alu_result;
                    rd_addr  <= instr_q[11:7];
                    rd_we_q  <= (instr_q[11:7] != 5'd0);
                    state    <= S_WB;
                end
                S_WB: begin
                    rd_we_q <= 1'b0;
                    state   <= S_IDLE;
                end
                S_ERR: begin
                    illegal_q <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural register file and ALU.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        illegal;
    logic        busy;

    logic [31:0] regs [32];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .rd_we       (rd_we),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .illegal     (illegal),
        .busy        (busy)
    );

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = alu_a << alu_b[4:0];
            3'b110: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
        endcase
    end

    always @(posedge clk) begin
        if (rst && regs[1] !== 32'd5) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            regs[1] <= 32'd5;
            regs[2] <= 32'd7;
            regs[6] <= 32'h8000_0000;
        end else if (rd_we) begin
            regs[rd_addr] <= rd_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction in IDLE; returns just after the accepting edge
    task automatic accept(input logic [31:0] w);
        instr_valid = 1'b1;
        instr       = w;
        step();
        instr_valid = 1'b0;
    endtask

    int acc_cyc [2];
    int n_acc;
    int n_wr;
    logic [4:0]  wr_addr [4];
    logic [31:0] wr_data [4];
    logic        rdy_prev;

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        step();
        step();
        chk("rst_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rd_we", {31'b0, rd_we}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
        chk("rst_rd_wdata", rd_wdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'b0, instr_ready}, 32'd1);

        // add x3,x1,x2
        accept(32'h0020_81B3);
        chk("add_busy", {31'b0, busy}, 32'd1);
        chk("add_ready_lo", {31'b0, instr_ready}, 32'd0);
        chk("add_rs1", {27'b0, rs1_addr}, 32'd1);
        chk("add_rs2", {27'b0, rs2_addr}, 32'd2);
        step();
        chk("add_ctrl", {29'b0, alu_ctrl}, 32'd0);
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_we_early", {31'b0, rd_we}, 32'd0);
        step();
        chk("add_we", {31'b0, rd_we}, 32'd1);
        chk("add_rd", {27'b0, rd_addr}, 32'd3);
        chk("add_wdata", rd_wdata, 32'd12);
        step();
        chk("add_we_once", {31'b0, rd_we}, 32'd0);
        chk("add_ready_back", {31'b0, instr_ready}, 32'd1);
        chk("add_x3", regs[3], 32'd12);

        // srai x5,x6,4
        accept(32'h4043_5293);
        step();
        chk("srai_ctrl", {29'b0, alu_ctrl}, 32'd7);
        chk("srai_a", alu_a, 32'h8000_0000);
        chk("srai_b", alu_b, 32'd4);
        step();
        chk("srai_we", {31'b0, rd_we}, 32'd1);
        chk("srai_rd", {27'b0, rd_addr}, 32'd5);
        chk("srai_wdata", rd_wdata, 32'hF800_0000);
        step();

        // slt x1,x2,x3 is unsupported
        accept(32'h0031_20B3);
        chk("slt_ill_early", {31'b0, illegal}, 32'd0);
        step();
        chk("slt_ill", {31'b0, illegal}, 32'd1);
        chk("slt_we", {31'b0, rd_we}, 32'd0);
        step();
        chk("slt_ill_once", {31'b0, illegal}, 32'd0);
        chk("slt_we_after", {31'b0, rd_we}, 32'd0);
        chk("slt_ready", {31'b0, instr_ready}, 32'd1);
        chk("slt_x1_kept", regs[1], 32'd5);

        // addi x0,x0,1: executes but never writes
        accept(32'h0010_0013);
        step();
        chk("addi_ctrl", {29'b0, alu_ctrl}, 32'd0);
        chk("addi_b", alu_b, 32'd1);
        step();
        chk("addi_busy_wb", {31'b0, busy}, 32'd1);
        chk("addi_we", {31'b0, rd_we}, 32'd0);
        step();
        chk("addi_ready", {31'b0, instr_ready}, 32'd1);

        // reset while in EXEC aborts the write
        accept(32'h0040_81B3);
        step();
        chk("abort_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        chk("abort_we", {31'b0, rd_we}, 32'd0);
        chk("abort_ready_in_rst", {31'b0, instr_ready}, 32'd0);
        chk("abort_wdata", rd_wdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'b0, instr_ready}, 32'd1);
        step();
        chk("abort_we_after", {31'b0, rd_we}, 32'd0);
        chk("abort_ill_after", {31'b0, illegal}, 32'd0);

        // sub x7,x2,x1 then or x8,x1,x2 with instr_valid held high
        n_acc = 0;
        n_wr  = 0;
        instr_valid = 1'b1;
        instr       = 32'h4011_03B3;
        for (int cyc = 0; cyc < 16; cyc++) begin
            rdy_prev = instr_ready;
            step();
            if (rdy_prev && instr_valid) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) instr = 32'h0020_E433;
                else            instr_valid = 1'b0;
            end
            if (rd_we && n_wr < 4) begin
                wr_addr[n_wr] = rd_addr;
                wr_data[n_wr] = rd_wdata;
                n_wr++;
            end
        end
        chk("b2b_accepts", n_acc, 32'd2);
        if (n_acc == 2) chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 32'd4);
        chk("b2b_writes", n_wr, 32'd2);
        if (n_wr == 2) begin
            chk("b2b_rd0", {27'b0, wr_addr[0]}, 32'd7);
            chk("b2b_wd0", wr_data[0], 32'd2);
            chk("b2b_rd1", {27'b0, wr_addr[1]}, 32'd8);
            chk("b2b_wd1", wr_data[1], 32'd7);
        end
        chk("b2b_x7", regs[7], 32'd2);
        chk("b2b_x8", regs[8], 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
